poly_firing_ctrl_p: RTL

- Parametrised firing controller for the polynomial-evaluation actor. It executes exactly one CFDF firing per start_fire request, in the mode given by mode_in: GET_CMD, INSTR or OUTPUT.
- GET_CMD fetches and decodes one command word. INSTR dispatches the decoded opcode to one of NUM_OPS external sub-FSMs (STP, EVP, EVB, RST) over a start/done handshake. OUTPUT writes result/status to the output FIFO under backpressure.
- New in this generation:
  - parametrised field widths and polynomial count
  - argument range checking
  - watchdog timeout on sub-FSMs
  - error status codes
  - computed next_mode_out for the parent scheduler.

---
 rtl/poly_firing_ctrl_p_if.sv | 44 ++++
 rtl/poly_firing_ctrl_p.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/poly_firing_ctrl_p_if.sv
// Handshake bundle between the polynomial firing controller (master) and its
// command FIFO, sub-FSM lanes, output FIFO and parent scheduler (slave).
interface poly_firing_ctrl_p_if #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_POLY  = 8,
    parameter int OP_W      = 3,
    parameter int ARG2_W    = 5,
    parameter int NUM_OPS   = 4
);
    localparam int A_W = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1;

    logic                 start_fire;
    logic [1:0]           mode_in;
    logic [WORD_SIZE-1:0] command_in;
    logic                 cmd_empty;
    logic                 rd_cmd;
    logic [NUM_OPS-1:0]   sub_start;
    logic [NUM_OPS-1:0]   sub_done;
    logic [WORD_SIZE-1:0] sub_result;
    logic [WORD_SIZE-1:0] sub_status;
    logic [OP_W-1:0]      instr;
    logic [A_W-1:0]       arg1;
    logic [ARG2_W-1:0]    arg2;
    logic                 out_full;
    logic                 en_wr_output_fifo;
    logic [WORD_SIZE-1:0] result;
    logic [WORD_SIZE-1:0] status;
    logic                 done_fire;
    logic [1:0]           next_mode_out;

    modport master (
        input  start_fire, mode_in, command_in, cmd_empty, sub_done,
               sub_result, sub_status, out_full,
        output rd_cmd, sub_start, instr, arg1, arg2, en_wr_output_fifo,
               result, status, done_fire, next_mode_out
    );

    modport slave (
        output start_fire, mode_in, command_in, cmd_empty, sub_done,
               sub_result, sub_status, out_full,
        input  rd_cmd, sub_start, instr, arg1, arg2, en_wr_output_fifo,
               result, status, done_fire, next_mode_out
    );
endinterface

// File: rtl/poly_firing_ctrl_p.sv
// One CFDF firing per start_fire: fetch/decode a command, dispatch it to a sub-FSM lane
// with a watchdog, or write result/status to the output FIFO under out_full backpressure.
module poly_firing_ctrl_p #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_POLY  = 8,
    parameter int OP_W      = 3,
    parameter int ARG2_W    = 5,
    parameter int NUM_OPS   = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic clk,
    input  logic rst,
    poly_firing_ctrl_p_if.master bus
);
    localparam int A_W  = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1;
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD_RD, S_CMD_LATCH, S_DISPATCH, S_WAIT, S_OUT_WAIT, S_OUT_WR, S_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [OP_W-1:0]      r_instr, w_instr_nxt;
    logic [A_W-1:0]       r_arg1, w_arg1_nxt;
    logic [ARG2_W-1:0]    r_arg2, w_arg2_nxt;
    logic [WORD_SIZE-1:0] r_result, w_result_nxt;
    logic [WORD_SIZE-1:0] r_status, w_status_nxt;
    logic [1:0]           r_next_mode, w_next_mode_nxt;
    logic [WD_W-1:0]      r_wd, w_wd_nxt;

    logic                 w_rd_cmd, w_en_wr, w_done_fire;
    logic [NUM_OPS-1:0]   w_sub_start, w_lane_oh;
    logic                 w_op_legal, w_a_bad, w_lane_done, w_wd_expire;
    logic [WD_W-1:0]      w_wd_inc;

    // Opcodes 1..4 map onto lanes 0..3; anything else leaves the one-hot empty.
    always_comb begin
        w_lane_oh = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (i < 4 && r_instr == OP_W'(i + 1)) w_lane_oh[i] = 1'b1;
        end
    end

    assign w_op_legal  = |w_lane_oh;
    assign w_a_bad     = ({1'b0, r_arg1} >= (A_W + 1)'(NUM_POLY));
    assign w_lane_done = |(bus.sub_done & w_lane_oh);
    assign w_wd_inc    = r_wd + WD_W'(1);
    // Expiry is flagged in the cycle the counter steps onto TIMEOUT-1.
    assign w_wd_expire = (w_wd_inc == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_instr_nxt     = r_instr;
        w_arg1_nxt      = r_arg1;
        w_arg2_nxt      = r_arg2;
        w_result_nxt    = r_result;
        w_status_nxt    = r_status;
        w_next_mode_nxt = r_next_mode;
        w_wd_nxt        = r_wd;
        w_rd_cmd        = 1'b0;
        w_sub_start     = '0;
        w_en_wr         = 1'b0;
        w_done_fire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_fire) begin
                    case (bus.mode_in)
                        2'b00: begin
                            if (bus.cmd_empty) begin
                                w_status_nxt    = WORD_SIZE'(4);
                                w_next_mode_nxt = 2'b00;
                                w_state_nxt     = S_DONE;
                            end else begin
                                w_state_nxt = S_CMD_RD;
                            end
                        end
                        2'b01:   w_state_nxt = S_DISPATCH;
                        2'b10:   w_state_nxt = S_OUT_WAIT;
                        default: begin
                            w_next_mode_nxt = 2'b00;
                            w_state_nxt     = S_DONE;
                        end
                    endcase
                end
            end
            S_CMD_RD: begin
                w_rd_cmd    = 1'b1;
                w_state_nxt = S_CMD_LATCH;
            end
            S_CMD_LATCH: begin
                w_instr_nxt     = bus.command_in[OP_W-1:0];
                w_arg1_nxt      = bus.command_in[OP_W +: A_W];
                w_arg2_nxt      = bus.command_in[OP_W + A_W +: ARG2_W];
                w_status_nxt    = '0;
                w_next_mode_nxt = 2'b01;
                w_state_nxt     = S_DONE;
            end
            S_DISPATCH: begin
                if (!w_op_legal || w_a_bad) begin
                    w_status_nxt    = !w_op_legal ? WORD_SIZE'(1) : WORD_SIZE'(3);
                    w_result_nxt    = '0;
                    w_next_mode_nxt = 2'b10;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_sub_start = w_lane_oh;
                    w_wd_nxt    = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_wd_nxt = w_wd_inc;
                if (w_lane_done) begin
                    w_state_nxt = S_DONE;
                    if (r_instr == OP_W'(4)) begin
                        w_instr_nxt     = '0;
                        w_arg1_nxt      = '0;
                        w_arg2_nxt      = '0;
                        w_result_nxt    = '0;
                        w_status_nxt    = '0;
                        w_next_mode_nxt = 2'b00;
                    end else begin
                        w_result_nxt    = bus.sub_result;
                        w_status_nxt    = bus.sub_status;
                        w_next_mode_nxt = 2'b10;
                    end
                end else if (w_wd_expire) begin
                    w_status_nxt    = WORD_SIZE'(2);
                    w_result_nxt    = '0;
                    w_next_mode_nxt = 2'b10;
                    w_state_nxt     = S_DONE;
                end
            end
            S_OUT_WAIT: begin
                if (!bus.out_full) w_state_nxt = S_OUT_WR;
            end
            S_OUT_WR: begin
                w_en_wr         = 1'b1;
                w_next_mode_nxt = 2'b00;
                w_state_nxt     = S_DONE;
            end
            S_DONE: begin
                w_done_fire = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= '0;
            r_arg1      <= '0;
            r_arg2      <= '0;
            r_result    <= '0;
            r_status    <= '0;
            r_next_mode <= 2'b00;
            r_wd        <= '0;
        end else begin
            r_instr     <= w_instr_nxt;
            r_arg1      <= w_arg1_nxt;
            r_arg2      <= w_arg2_nxt;
            r_result    <= w_result_nxt;
            r_status    <= w_status_nxt;
            r_next_mode <= w_next_mode_nxt;
            r_wd        <= w_wd_nxt;
        end
    end

    assign bus.rd_cmd            = w_rd_cmd;
    assign bus.sub_start         = w_sub_start;
    assign bus.en_wr_output_fifo = w_en_wr;
    assign bus.done_fire         = w_done_fire;
    assign bus.instr             = r_instr;
    assign bus.arg1              = r_arg1;
    assign bus.arg2              = r_arg2;
    assign bus.result            = r_result;
    assign bus.status            = r_status;
    assign bus.next_mode_out     = r_next_mode;
endmodule
